// File: rtl/imuldiv_int_mul_div_param.sv
// ---------------------------------------------------------------------------
// imuldiv_int_mul_div_param
//
// Iterative integer multiply / divide / multiply-accumulate unit.
// One radix-2 step per cycle: shift-add for products, restoring
// shift-subtract for quotients. Both operate on operand magnitudes, and the
// signs are applied when the result is written.
//
// Ports
//   clk                    single clock, rising edge
//   reset                  asynchronous, active-high
//   muldivreq_msg_fn[2:0]  0 MUL, 1 MULU, 2 DIV, 3 DIVU, 4 MAC, 5-7 MUL
//   muldivreq_msg_a/b/c    W-bit operands (c only used by MAC)
//   muldivreq_val/rdy      request handshake (rdy only in IDLE)
//   muldivresp_msg_result  2W-bit result; for divides {remainder, quotient}
//   muldivresp_val/rdy     response handshake (val only in DONE)
//
// Build option
//   IMULDIV_EARLY_TERM_EN  when defined, MUL/MULU/MAC leave CALC once the
//                          remaining multiplier bits are all zero. Divides
//                          always take W cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; operands captured on val && rdy
// CALC  | one shift-add / shift-subtract step per cycle
// DONE  | result valid, held until muldivresp_rdy
// ---------------------------------------------------------------------------
module imuldiv_int_mul_div_param #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     muldivreq_msg_fn,
    input  logic [W-1:0]   muldivreq_msg_a,
    input  logic [W-1:0]   muldivreq_msg_b,
    input  logic [W-1:0]   muldivreq_msg_c,
    input  logic           muldivreq_val,
    output logic           muldivreq_rdy,
    output logic [2*W-1:0] muldivresp_msg_result,
    output logic           muldivresp_val,
    input  logic           muldivresp_rdy
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] FN_MULU = 3'd1;
    localparam logic [2:0] FN_DIV  = 3'd2;
    localparam logic [2:0] FN_DIVU = 3'd3;
    localparam logic [2:0] FN_MAC  = 3'd4;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic           op_div;
    logic           op_mac;
    logic           sign_a;
    logic           sign_b;
    logic [W-1:0]   c_reg;

    // multiply datapath
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;

    // divide datapath: quo starts as the dividend and fills with quotient bits
    logic [W-1:0]   rem;
    logic [W-1:0]   quo;
    logic [W-1:0]   dvsr;

    logic [2*W-1:0] result;

    // request decode
    logic           accept;
    logic           req_div;
    logic           req_signed;
    logic           req_sign_a;
    logic           req_sign_b;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;

    // step / finish logic
    logic [2*W-1:0] mul_add;
    logic [W-1:0]   mplier_nxt;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_diff;
    logic           rem_ok;
    logic [W-1:0]   rem_nxt;
    logic [W-1:0]   quo_nxt;
    logic           last_step;
    logic [2*W-1:0] prod_fin;
    logic [W-1:0]   q_fin;
    logic [W-1:0]   r_fin;
    logic [2*W-1:0] res_fin;

    assign muldivreq_rdy         = (state == IDLE);
    assign muldivresp_val        = (state == DONE);
    assign muldivresp_msg_result = result;

    assign accept     = muldivreq_val && muldivreq_rdy;
    assign req_div    = (muldivreq_msg_fn == FN_DIV) || (muldivreq_msg_fn == FN_DIVU);
    assign req_signed = !((muldivreq_msg_fn == FN_MULU) || (muldivreq_msg_fn == FN_DIVU));
    assign req_sign_a = req_signed && muldivreq_msg_a[W-1];
    assign req_sign_b = req_signed && muldivreq_msg_b[W-1];
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
    assign a_mag      = req_sign_a ? -muldivreq_msg_a : muldivreq_msg_a;
    assign b_mag      = req_sign_b ? -muldivreq_msg_b : muldivreq_msg_b;

    always_comb begin
        mul_add    = mplier[0] ? (acc + mcand) : acc;
        mplier_nxt = mplier >> 1;

        rem_sh     = {rem, quo[W-1]};
        rem_diff   = rem_sh - {1'b0, dvsr};
        rem_ok     = !rem_diff[W];
        rem_nxt    = rem_ok ? rem_diff[W-1:0] : rem_sh[W-1:0];
        quo_nxt    = {quo[W-2:0], rem_ok};

        prod_fin   = (sign_a ^ sign_b) ? -mul_add : mul_add;
        if (op_mac) begin
            prod_fin = prod_fin + {{W{c_reg[W-1]}}, c_reg};
        end

        // A zero divisor naturally yields remainder = |a|, and re-applying
        // the dividend sign turns that back into a; only the quotient needs
        // forcing, since the sign fix would otherwise disturb the all-ones.
        q_fin      = (sign_a ^ sign_b) ? -quo_nxt : quo_nxt;
        r_fin      = sign_a ? -rem_nxt : rem_nxt;
        if (dvsr == '0) begin
            q_fin = '1;
        end

        res_fin    = op_div ? {r_fin, q_fin} : prod_fin;
    end

`ifdef IMULDIV_EARLY_TERM_EN
    // Once the unconsumed multiplier bits are zero no further adds can occur.
    assign last_step = (cnt == CW'(1)) || (!op_div && (mplier_nxt == '0));
`else
    assign last_step = (cnt == CW'(1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            op_mac <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            c_reg  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div <= req_div;
                        op_mac <= (muldivreq_msg_fn == FN_MAC);
                        sign_a <= req_sign_a;
                        sign_b <= req_sign_b;
                        c_reg  <= muldivreq_msg_c;
                        acc    <= '0;
                        mcand  <= {{W{1'b0}}, a_mag};
                        mplier <= b_mag;
                        rem    <= '0;
                        quo    <= a_mag;
                        dvsr   <= b_mag;
                        cnt    <= CW'(W);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (op_div) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                    end else begin
                        acc    <= mul_add;
                        mcand  <= mcand << 1;
                        mplier <= mplier_nxt;
                    end
                    if (last_step) begin
                        result <= res_fin;
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    // rdy stays low on this edge, so no request can be taken
                    // in the same cycle as the handshake.
                    if (muldivresp_rdy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imuldiv_int_mul_div_param.sv
module tb_imuldiv_int_mul_div_param;

    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic [2:0]     req_fn;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [W-1:0]   req_c;
    logic           req_val;
    logic           req_rdy;
    logic [2*W-1:0] resp_result;
    logic           resp_val;
    logic           resp_rdy;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb_q[$];
    int          lat_q[$];

    imuldiv_int_mul_div_param #(.W(W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .muldivreq_msg_fn      (req_fn),
        .muldivreq_msg_a       (req_a),
        .muldivreq_msg_b       (req_b),
        .muldivreq_msg_c       (req_c),
        .muldivreq_val         (req_val),
        .muldivreq_rdy         (req_rdy),
        .muldivresp_msg_result (resp_result),
        .muldivresp_val        (resp_val),
        .muldivresp_rdy        (resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model built on native SystemVerilog arithmetic.
    function automatic logic [63:0] model(input logic [2:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
        longint sa, sb, sc;
        int q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        case (fn)
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return sa * sb + sc;
            default: return sa * sb;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] fn, input logic [31:0] b);
`ifdef IMULDIV_EARLY_TERM_EN
        logic [31:0] m;
        int n;
        if (fn == 3'd2 || fn == 3'd3) return W;
        m = (fn != 3'd1 && b[31]) ? -b : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n;
`else
        return W;
`endif
    endfunction

    task automatic scramble(input logic with_val);
        req_fn = 3'($urandom_range(0, 7));
        req_a  = $urandom;
        req_b  = $urandom;
        req_c  = $urandom;
        if (with_val) req_val = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c,
                         input logic [63:0] exp, input int hold);
        int lat;
        int e_lat;
        logic [63:0] e;
        @(negedge clk);
        chk({tag, "_req_rdy"}, 64'(req_rdy), 64'd1);
        req_fn  = fn;
        req_a   = a;
        req_b   = b;
        req_c   = c;
        req_val = 1'b1;
        sb_q.push_back(exp);
        lat_q.push_back(model_lat(fn, b));
        @(posedge clk);
        #1;
        req_val = 1'b0;
        scramble(1'b0);
        lat = 0;
        while (!resp_val && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            scramble(1'b0);
        end
        e     = sb_q.pop_front();
        e_lat = lat_q.pop_front();
        chk({tag, "_resp_val"}, 64'(resp_val), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(e_lat));
        chk({tag, "_result"}, resp_result, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            scramble(1'b1);
            chk({tag, "_hold_val"}, 64'(resp_val), 64'd1);
            chk({tag, "_hold_result"}, resp_result, e);
            chk({tag, "_hold_req_rdy"}, 64'(req_rdy), 64'd0);
        end
        @(negedge clk);
        req_val  = 1'b1;
        resp_rdy = 1'b1;
        chk({tag, "_hs_req_rdy"}, 64'(req_rdy), 64'd0);
        @(posedge clk);
        #1;
        resp_rdy = 1'b0;
        chk({tag, "_post_req_rdy"}, 64'(req_rdy), 64'd1);
        chk({tag, "_post_val"}, 64'(resp_val), 64'd0);
        req_val = 1'b0;
    endtask

    initial begin
        logic [2:0]  fn;
        logic [31:0] a, b, c;
        int seen;
        int wait_cnt;

        reset    = 1'b1;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        req_fn   = 3'd0;
        req_a    = '0;
        req_b    = '0;
        req_c    = '0;
        repeat (2) @(negedge clk);
        chk("reset_req_rdy", 64'(req_rdy), 64'd1);
        chk("reset_resp_val", 64'(resp_val), 64'd0);
        chk("reset_result", resp_result, 64'd0);
        reset = 1'b0;

        do_op("mul_neg", 3'd0, -32'sd3, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        do_op("div_neg", 3'd2, -32'sd7, 32'd2, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        do_op("divu_zero", 3'd3, 32'd7, 32'd0, 32'd0, {32'h0000_0007, 32'hFFFF_FFFF}, 0);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, {32'h0000_0000, 32'h8000_0000}, 0);
        do_op("mac", 3'd4, 32'd5, 32'd6, 32'hFFFF_FFFF, 64'h0000_0000_0000_001D, 0);
        do_op("mulu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 64'hFFFF_FFFE_0000_0001, 0);
        do_op("div_zero_neg", 3'd2, -32'sd5, 32'd0, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0);
        do_op("fn6_mul", 3'd6, -32'sd2, -32'sd3, 32'd0, 64'd6, 0);
        do_op("mulu_9x3", 3'd1, 32'd9, 32'd3, 32'd0, 64'd27, 0);
        do_op("hold", 3'd0, 32'd1234, -32'sd5678, 32'd0, model(3'd0, 32'd1234, -32'sd5678, 32'd0), 5);

        for (int i = 0; i < 6; i++) begin
            fn = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            c  = $urandom;
            do_op("rand", fn, a, b, c, model(fn, a, b, c), 0);
        end

        // reset in the middle of CALC
        @(negedge clk);
        req_fn = 3'd0; req_a = 32'd11; req_b = 32'd13; req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_calc_val", 64'(resp_val), 64'd0);
        chk("rst_calc_req_rdy", 64'(req_rdy), 64'd1);
        chk("rst_calc_result", resp_result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (resp_val) seen++;
        end
        chk("rst_calc_no_resp", 64'(seen), 64'd0);

        // reset while a response is waiting in DONE
        @(negedge clk);
        req_fn = 3'd1; req_a = 32'd4; req_b = 32'd5; req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        wait_cnt = 0;
        while (!resp_val && wait_cnt < 300) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        chk("rst_done_pre_val", 64'(resp_val), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_done_val", 64'(resp_val), 64'd0);
        chk("rst_done_req_rdy", 64'(req_rdy), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        do_op("after_reset", 3'd3, 32'd100, 32'd7, 32'd0, {32'd2, 32'd14}, 0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imuldiv_int_mul_div_param.md
IMULDIV_INT_MUL_DIV_PARAM -- requirements
Module: imuldiv_IntMulDivParam

Interface
REQ-001 SHALL have parameter W, default 32, operand width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port muldivreq_msg_fn  input  3  operation: 0 MUL, 1 MULU, 2 DIV, 3 DIVU, 4 MAC; 5-7 behave as MUL.
REQ-005 SHALL have ports muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c  input  W each  operands; c is used by MAC only.
REQ-006 SHALL have port muldivreq_val  input  1  request valid.
REQ-007 SHALL have port muldivreq_rdy  output  1  request ready.
REQ-008 SHALL have port muldivresp_msg_result  output  2W  result.
REQ-009 SHALL have port muldivresp_val  output  1  response valid.
REQ-010 SHALL have port muldivresp_rdy  input  1  response ready.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 SHALL assert muldivreq_rdy only in IDLE.
REQ-013 SHALL accept a request (register fn, a, b, c, operand signs) on the edge where val && rdy, then go to CALC.
REQ-014 SHALL run one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle in CALC, on operand magnitudes for signed ops, with a counter that stops after exactly W steps.
REQ-015 SHALL go to DONE on the edge of step W, and assert muldivresp_val only in DONE; the response therefore appears W edges after the accepting edge.
REQ-016 SHALL hold the result and muldivresp_val stable in DONE until muldivresp_rdy is high, then return to IDLE on that edge.
REQ-017 SHALL NOT accept a new request in the cycle of a DONE->IDLE transition (no back-to-back overlap; rdy rises the following cycle).
REQ-018 MUL/MULU: result = full 2W-bit signed/unsigned product a*b.
REQ-019 MAC: result = signed product a*b plus sign-extended c, truncated modulo 2^(2W).
REQ-020 DIV/DIVU: result = {remainder[W-1:0], quotient[W-1:0]}; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-021 Divide by zero: quotient = all ones, remainder = a.
REQ-022 Signed overflow (a = -2^(W-1), b = -1, DIV): quotient = a, remainder = 0.
REQ-023 Operand inputs SHALL be ignored outside the accepting edge; changing them during CALC/DONE SHALL NOT affect the result.

Reset
REQ-024 SHALL on reset force state IDLE, counter 0, result register 0, muldivreq_rdy = 1, muldivresp_val = 0.
REQ-025 Reset asserted mid-CALC or in DONE SHALL abort the operation with no response produced.

Configuration
REQ-026 Macro IMULDIV_EARLY_TERM_EN defined: MUL, MULU and MAC SHALL leave CALC as soon as the remaining unshifted multiplier magnitude is zero (minimum 1 CALC cycle); DIV/DIVU SHALL be unaffected.
REQ-027 Macro not defined: every operation SHALL take exactly W CALC cycles.

Verification (W = 32)
REQ-028 MUL a=-3, b=7 -> result 0xFFFFFFFF_FFFFFFEB, resp_val 32 edges after accept.
REQ-029 DIV a=-7, b=2 -> result {0xFFFFFFFF, 0xFFFFFFFD}; DIVU a=7, b=0 -> {0x00000007, 0xFFFFFFFF}.
REQ-030 DIV a=0x80000000, b=0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-031 MAC a=5, b=6, c=-1 -> 0x00000000_0000001D; MULU a=b=0xFFFFFFFF -> 0xFFFFFFFE_00000001.
REQ-032 Hold muldivresp_rdy low 5 cycles in DONE while toggling inputs -> result and val stable; rdy low until 1 cycle after the handshake.
REQ-033 Assert reset at CALC step 10 -> val 0 and rdy 1 immediately; with IMULDIV_EARLY_TERM_EN, MULU a=9, b=3 -> response after 2 CALC cycles, value 27.
